// File: rtl/ym3438_phase_sched.sv
// Two-phase (c1/c2) enable generator with operator-slot tracking and a
// single-request write scheduler that aligns a write strobe with a slot's c1.
module ym3438_phase_sched #(
  parameter int DIV    = 6,
  parameter int SLOTS  = 24,
  parameter int SLOT_W = 5
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              hold,
  output logic              c1,
  output logic              c2,
  output logic [SLOT_W-1:0] slot,
  output logic              sync,
  input  logic              wr_req,
  input  logic [SLOT_W-1:0] wr_slot,
  output logic              wr_en,
  output logic              wr_ack,
  output logic              wr_err,
  output logic              busy
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0]     P_C1      = PW'(DIV - 1);
  localparam logic [PW-1:0]     P_C2      = PW'(DIV / 2 - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS - 1);
  localparam logic [SLOT_W:0]   SLOT_LIM  = (SLOT_W + 1)'(SLOTS);

  typedef enum logic [1:0] {IDLE, WAIT, ISSUE, ACK} state_t;

  state_t            state;
  logic [PW-1:0]     pcnt;
  logic [SLOT_W-1:0] tgt;
  logic              err;
  logic              c1_set;
  logic              c2_set;
  logic              tgt_bad;

  // Phase pulses are decided from the prescaler before it advances, so the
  // registered c1/c2 land exactly one cycle after the qualifying edge.
  assign c1_set  = !hold && (pcnt == P_C1);
  assign c2_set  = !hold && (pcnt == P_C2);
  assign tgt_bad = {1'b0, tgt} >= SLOT_LIM;

  always_ff @(posedge MCLK) begin
    if (reset) begin
      pcnt   <= '0;
      slot   <= '0;
      c1     <= 1'b0;
      c2     <= 1'b0;
      sync   <= 1'b0;
      wr_en  <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
      state  <= IDLE;
    end else begin
      if (!hold)
        pcnt <= (pcnt == P_C1) ? '0 : pcnt + 1'b1;
      c1   <= c1_set;
      c2   <= c2_set;
      // slot only moves on c2, so it is the same value throughout any c1 pulse
      sync <= c1_set && (slot == '0);
      if (c2)
        slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;

      wr_en  <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      case (state)
        IDLE: begin
          err <= 1'b0;
          if (wr_req) begin
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          // the range check runs on the latched target, one edge after capture
          if (tgt_bad) begin
            err   <= 1'b1;
            state <= ISSUE;
          end else if (c1_set && (slot == tgt)) begin
            wr_en <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          wr_ack <= 1'b1;
          wr_err <= err;
          state  <= ACK;
        end
        ACK: begin
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (state == IDLE && wr_req)
      tgt <= wr_slot;
  end

endmodule

// File: tb/tb_ym3438_phase_sched.sv
// Directed bench for ym3438_phase_sched: phase timing, slot rotation, write
// scheduling, out-of-range writes, hold and reset behaviour.
module tb_ym3438_phase_sched;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       hold = 1'b0;
  logic       c1, c2, sync;
  logic [4:0] slot;
  logic       wr_req = 1'b0;
  logic [4:0] wr_slot = '0;
  logic       wr_en, wr_ack, wr_err, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ym3438_phase_sched #(.DIV(6), .SLOTS(24), .SLOT_W(5)) dut (
    .MCLK(MCLK), .reset(reset), .hold(hold),
    .c1(c1), .c2(c2), .slot(slot), .sync(sync),
    .wr_req(wr_req), .wr_slot(wr_slot),
    .wr_en(wr_en), .wr_ack(wr_ack), .wr_err(wr_err), .busy(busy)
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
    cyc++;
  endtask

  // Cycle n is the cycle after the n-th edge sampling reset=0.
  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk("rst_c1", c1, 0);
    chk("rst_c2", c2, 0);
    chk("rst_slot", slot, 0);
    chk("rst_sync", sync, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    cyc = 0;
  endtask

  // Free-running slot value in cycle n (slot advances on the edge after c2).
  function automatic int slot_at(int n);
    return ((n + 2) / 6) % 24;
  endfunction

  // Effective free-run cycle for the hold test: edges 21..40 are frozen.
  function automatic int eff(int n);
    if (n <= 20) return n;
    if (n <= 40) return -1;
    return n - 20;
  endfunction

  initial begin
    // phase timing, slot rotation and sync over a full sample cycle
    do_reset();
    for (int i = 1; i <= 150; i++) begin
      tick();
      chk("c1", c1, int'(cyc % 6 == 0));
      chk("c2", c2, int'(cyc % 6 == 3));
      chk("c1c2_overlap", int'(c1 & c2), 0);
      chk("slot", slot, slot_at(cyc));
      chk("sync", sync, int'(cyc == 144));
      chk("idle_wr_en", wr_en, 0);
    end

    // in-range write: request slot 5 while slot is 2
    do_reset();
    while (cyc < 12) tick();
    chk("pre_slot", slot, 2);
    wr_req = 1'b1; wr_slot = 5'd5;
    tick();
    wr_req = 1'b0;
    chk("cap_busy", busy, 1);
    while (cyc < 34) begin
      tick();
      chk("w5_wr_en", wr_en, int'(cyc == 30));
      chk("w5_wr_ack", wr_ack, int'(cyc == 31));
      chk("w5_wr_err", wr_err, 0);
      chk("w5_busy", busy, int'(cyc <= 31));
      if (cyc == 30) chk("w5_slot_at_en", slot, 5);
      if (cyc == 30) chk("w5_c1_at_en", c1, 1);
    end

    // out-of-range write
    do_reset();
    while (cyc < 2) tick();
    wr_req = 1'b1; wr_slot = 5'd30;
    tick();
    wr_req = 1'b0;
    chk("oor_busy", busy, 1);
    while (cyc < 40) begin
      tick();
      chk("oor_wr_en", wr_en, 0);
      chk("oor_wr_ack", wr_ack, int'(cyc == 5));
      chk("oor_wr_err", wr_err, int'(cyc == 5));
      chk("oor_busy", busy, int'(cyc <= 5));
    end

    // hold for 20 edges in the middle of a wait
    do_reset();
    while (cyc < 12) tick();
    wr_req = 1'b1; wr_slot = 5'd5;
    tick();
    wr_req = 1'b0;
    while (cyc < 56) begin
      if (cyc == 20) hold = 1'b1;
      if (cyc == 40) hold = 1'b0;
      tick();
      begin
        int e;
        e = eff(cyc);
        chk("hold_c1", c1, int'(e > 0 && e % 6 == 0));
        chk("hold_c2", c2, int'(e > 0 && e % 6 == 3));
        chk("hold_slot", slot, (e < 0) ? 3 : slot_at(e));
        chk("hold_wr_en", wr_en, int'(cyc == 50));
        chk("hold_wr_ack", wr_ack, int'(cyc == 51));
        chk("hold_busy", busy, int'(cyc <= 51));
      end
    end

    // reset while waiting drops the request
    do_reset();
    while (cyc < 12) tick();
    wr_req = 1'b1; wr_slot = 5'd5;
    tick();
    wr_req = 1'b0;
    while (cyc < 20) tick();
    chk("mid_busy", busy, 1);
    chk("mid_slot", slot, 3);
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_wr_ack", wr_ack, 0);
      chk("post_rst_busy", busy, 0);
    end

    // capture on the same edge as the matching c1 waits a full rotation
    do_reset();
    while (cyc < 5) tick();
    wr_req = 1'b1; wr_slot = 5'd1;
    tick();
    wr_req = 1'b0;
    chk("coin_c1", c1, 1);
    chk("coin_slot", slot, 1);
    chk("coin_wr_en", wr_en, 0);
    while (cyc < 153) begin
      tick();
      chk("coin_wr_en", wr_en, int'(cyc == 150));
      chk("coin_wr_ack", wr_ack, int'(cyc == 151));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
